// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
// Purpose : valid/ready word stream that feeds the instruction-memory boot
//           loader (bench driver today, UART bridge later).
// Signals : s_valid  source -> sink  word valid
//           s_data   source -> sink  DATA_W-bit stream word
//           s_ready  sink -> source  sink accepts; transfer = s_valid & s_ready
// Modports: master = stream source, slave = loader side
// ---------------------------------------------------------------------------
interface imem_boot_loader_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input  s_ready);
  modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
// Purpose : streams a program image into instruction memory and keeps the
//           core in reset until the whole image is written and its XOR
//           checksum matches. Frame = length word, N payload words, checksum.
// Ports   : clk, reset      clock, synchronous active-high reset
//           s (slave)       stream input (s_valid / s_data / s_ready)
//           imem_we/addr/wdata  imem write port, one pulse per payload word
//           core_reset      high while the core must stay held
//           load_done       image verified, core released (sticky)
//           load_err        bad length or checksum (sticky until reset)
//           word_cnt        payload words written in the current frame
// ---------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  imem_boot_loader_if.slave s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  localparam int HW = (RST_HOLD < 2) ? 1 : $clog2(RST_HOLD + 1);
  // Largest legal length: a full imem, which needs the extra count bit.
  localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_WAIT_LEN, S_LOAD, S_CHECK, S_HOLD, S_RUN, S_ERROR
  } state_e;

  state_e              state_q, state_d;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [DATA_W-1:0]   imem_wdata_q;
  logic [ADDR_W:0]     word_cnt_q;
  logic [ADDR_W:0]     len_q;
  logic [DATA_W-1:0]   acc_q;
  logic [HW-1:0]       hold_q;

  logic                hs;
  logic [ADDR_W:0]     len_in;
  logic                len_bad;
  logic                last_word;

  assign hs        = s.s_valid & s.s_ready;
  assign len_in    = s.s_data[ADDR_W:0];
  assign len_bad   = (len_in == '0) || (len_in > CAP);
  assign last_word = (word_cnt_q + 1'b1) == len_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_WAIT_LEN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_LEN: if (hs) state_d = len_bad ? S_ERROR : S_LOAD;
      S_LOAD:     if (hs && last_word) state_d = S_CHECK;
      // acc_q already holds the last payload word: it was folded in on accept.
      S_CHECK:    if (hs) state_d = (s.s_data == acc_q) ? S_HOLD : S_ERROR;
      // Leave on the cycle the counter steps 1 -> 0, so HOLD lasts RST_HOLD cycles.
      S_HOLD:     if (hold_q == HW'(1)) state_d = S_RUN;
      S_RUN:      state_d = S_RUN;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  // Outputs decoded from state only; s_ready never looks at s_valid.
  always_comb begin
    s.s_ready  = 1'b0;
    core_reset = 1'b1;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state_q)
      S_WAIT_LEN, S_LOAD, S_CHECK: s.s_ready = !reset;
      S_RUN: begin
        core_reset = 1'b0;
        load_done  = 1'b1;
      end
      S_ERROR: load_err = 1'b1;
      default: ;
    endcase
  end

  // Datapath: length, write port, counters, checksum accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      word_cnt_q   <= '0;
      len_q        <= '0;
      acc_q        <= '0;
      hold_q       <= '0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        S_WAIT_LEN: if (hs) len_q <= len_in;
        S_LOAD: if (hs) begin
          imem_we_q    <= 1'b1;
          imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
          imem_wdata_q <= s.s_data;
          word_cnt_q   <= word_cnt_q + 1'b1;
          acc_q        <= acc_q ^ s.s_data;
        end
        S_CHECK: if (hs) hold_q <= HW'(RST_HOLD);
        S_HOLD:  hold_q <= hold_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
// Directed frames into imem_boot_loader with hand-computed expectations:
// continuous and gapped good frames, bad checksum, illegal lengths, a full
// 64-word image, and reset in the middle of a load.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;
  localparam int AW = 6;
  localparam int DW = 32;
  localparam int RH = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          core_reset, load_done, load_err;
  logic [AW:0]   word_cnt;

  imem_boot_loader_if #(.DATA_W(DW)) sif ();

  imem_boot_loader #(.ADDR_W(AW), .DATA_W(DW), .RST_HOLD(RH)) dut (
    .clk        (clk),
    .reset      (reset),
    .s          (sif.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_reset (core_reset),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_cnt   (word_cnt)
  );

  always #5 clk = ~clk;

  // cyc = index of the cycle that started at the latest rising edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Write / release monitor, sampled mid-cycle.
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int            wc[$];
  int            fall_cyc = -1;
  logic          prev_cr = 1'b1;
  always @(negedge clk) begin
    if (imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
      wc.push_back(cyc);
    end
    if (prev_cr && !core_reset) fall_cyc = cyc;
    prev_cr = core_reset;
  end

  int n_cmp = 0;
  int n_err = 0;
  int last_hs = 0;

  logic [DW-1:0] prog [4] = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h0000006F};
  localparam logic [DW-1:0] PROG_CKS = 32'h00D0805C;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sif.s_valid = 1'b0;
    sif.s_data  = 32'hDEADBEEF;
  endtask

  // Present one word after `gap` idle cycles; last_hs = its handshake cycle.
  task automatic send(input logic [DW-1:0] w, input int gap);
    int t;
    if (gap > 0) begin
      idle();
      repeat (gap) step();
    end
    sif.s_valid = 1'b1;
    sif.s_data  = w;
    t = 0;
    while (!sif.s_ready && t < 20) begin
      step();
      t++;
    end
    chk("send_ready", {63'd0, sif.s_ready}, 64'd1);
    last_hs = cyc;
    step();
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    fall_cyc = -1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    #1;
    clear_log();
  endtask

  int ck_hs;

  initial begin
    idle();
    // ---- reset values ----
    step();
    step();
    chk("rst_s_ready",    {63'd0, sif.s_ready}, 64'd0);
    chk("rst_core_reset", {63'd0, core_reset},  64'd1);
    chk("rst_load_done",  {63'd0, load_done},   64'd0);
    chk("rst_load_err",   {63'd0, load_err},    64'd0);
    chk("rst_word_cnt",   {57'd0, word_cnt},    64'd0);
    chk("rst_imem_we",    {63'd0, imem_we},     64'd0);
    chk("rst_imem_addr",  {58'd0, imem_addr},   64'd0);
    chk("rst_imem_wdata", {32'd0, imem_wdata},  64'd0);
    reset = 1'b0;
    #1;
    chk("wait_len_ready", {63'd0, sif.s_ready}, 64'd1);
    clear_log();

    // ---- continuous good frame ----
    send(32'd4, 0);
    for (int i = 0; i < 4; i++) send(prog[i], 0);
    send(PROG_CKS, 0);
    ck_hs = last_hs;
    idle();
    repeat (6) step();
    chk("c_nwrites", wa.size(), 64'd4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk("c_addr", {58'd0, wa[i]}, i);
      chk("c_data", {32'd0, wd[i]}, {32'd0, prog[i]});
      chk("c_b2b",  wc[i] - wc[0], i);
    end
    chk("c_release_lat", fall_cyc - ck_hs, RH + 1);
    if (wc.size() == 4) chk("c_last_wr_gap", fall_cyc - wc[3], RH + 1);
    chk("c_core_reset", {63'd0, core_reset},  64'd0);
    chk("c_load_done",  {63'd0, load_done},   64'd1);
    chk("c_load_err",   {63'd0, load_err},    64'd0);
    chk("c_word_cnt",   {57'd0, word_cnt},    64'd4);
    chk("c_s_ready",    {63'd0, sif.s_ready}, 64'd0);

    // ---- gapped good frame (valid 1,0,1,0...) ----
    do_reset();
    chk("rerun_core_reset", {63'd0, core_reset}, 64'd1);
    send(32'd4, 1);
    for (int i = 0; i < 4; i++) send(prog[i], 1);
    send(PROG_CKS, 1);
    idle();
    repeat (6) step();
    chk("g_nwrites", wa.size(), 64'd4);
    for (int i = 0; i < 4 && i < wa.size(); i++) begin
      chk("g_addr", {58'd0, wa[i]}, i);
      chk("g_data", {32'd0, wd[i]}, {32'd0, prog[i]});
      chk("g_spacing", wc[i] - wc[0], 2 * i);
    end
    if (wc.size() == 4) chk("g_last_wr_gap_ok", {63'd0, (fall_cyc - wc[3]) >= RH + 1}, 64'd1);
    chk("g_load_done",  {63'd0, load_done},  64'd1);
    chk("g_core_reset", {63'd0, core_reset}, 64'd0);
    chk("g_word_cnt",   {57'd0, word_cnt},   64'd4);

    // ---- bad checksum: 1^2^3 = 0, send 1 ----
    do_reset();
    send(32'd3, 0);
    send(32'd1, 0);
    send(32'd2, 0);
    send(32'd3, 0);
    send(32'd1, 0);
    step();
    chk("bc_load_err",   {63'd0, load_err},    64'd1);
    chk("bc_core_reset", {63'd0, core_reset},  64'd1);
    chk("bc_s_ready",    {63'd0, sif.s_ready}, 64'd0);
    chk("bc_load_done",  {63'd0, load_done},   64'd0);
    chk("bc_word_cnt",   {57'd0, word_cnt},    64'd3);
    sif.s_valid = 1'b1;
    sif.s_data  = 32'h12345678;
    repeat (3) step();
    idle();
    step();
    chk("bc_nwrites",      wa.size(), 64'd3);
    chk("bc_err_sticky",   {63'd0, load_err},   64'd1);
    chk("bc_core_reset2",  {63'd0, core_reset}, 64'd1);

    // ---- len = 0 ----
    do_reset();
    send(32'd0, 0);
    chk("l0_load_err", {63'd0, load_err},    64'd1);
    chk("l0_s_ready",  {63'd0, sif.s_ready}, 64'd0);
    idle();
    repeat (3) step();
    chk("l0_nwrites",  wa.size(), 64'd0);
    chk("l0_core_rst", {63'd0, core_reset}, 64'd1);

    // ---- len = 65 (one past capacity) ----
    do_reset();
    send(32'd65, 0);
    chk("l65_load_err", {63'd0, load_err},    64'd1);
    chk("l65_s_ready",  {63'd0, sif.s_ready}, 64'd0);
    sif.s_valid = 1'b1;
    sif.s_data  = 32'h0;
    repeat (3) step();
    idle();
    step();
    chk("l65_nwrites",  wa.size(), 64'd0);
    chk("l65_word_cnt", {57'd0, word_cnt}, 64'd0);

    // ---- len = 64 full image, word i = i, checksum XOR 0..63 = 0 ----
    do_reset();
    send(32'd64, 0);
    for (int i = 0; i < 64; i++) send(i, 0);
    send(32'd0, 0);
    idle();
    repeat (6) step();
    chk("f_nwrites", wa.size(), 64'd64);
    for (int i = 0; i < 64 && i < wa.size(); i++) begin
      chk("f_addr", {58'd0, wa[i]}, i);
      chk("f_data", {32'd0, wd[i]}, i);
    end
    chk("f_word_cnt",  {57'd0, word_cnt},  64'd64);
    chk("f_last_addr", {58'd0, imem_addr}, 64'd63);
    chk("f_load_done", {63'd0, load_done}, 64'd1);
    chk("f_load_err",  {63'd0, load_err},  64'd0);

    // ---- reset after 2 of 4 payload words, then fresh len=2 frame ----
    do_reset();
    send(32'd4, 0);
    send(prog[0], 0);
    send(prog[1], 0);
    idle();
    reset = 1'b1;
    #1;
    chk("mr_ready_in_rst", {63'd0, sif.s_ready}, 64'd0);
    step();
    chk("mr_core_reset", {63'd0, core_reset}, 64'd1);
    chk("mr_word_cnt",   {57'd0, word_cnt},   64'd0);
    chk("mr_imem_addr",  {58'd0, imem_addr},  64'd0);
    reset = 1'b0;
    #1;
    chk("mr_wait_len", {63'd0, sif.s_ready}, 64'd1);
    clear_log();
    // Upper bits of the length word are ignored: len = 2.
    send(32'hABCD0002, 0);
    send(32'h00000011, 0);
    send(32'h00000022, 0);
    send(32'h00000033, 0);
    ck_hs = last_hs;
    idle();
    repeat (6) step();
    chk("mr_nwrites", wa.size(), 64'd2);
    for (int i = 0; i < 2 && i < wa.size(); i++) chk("mr_addr", {58'd0, wa[i]}, i);
    if (wd.size() == 2) chk("mr_data1", {32'd0, wd[1]}, 64'h22);
    chk("mr_release_lat", fall_cyc - ck_hs, RH + 1);
    chk("mr_load_done",   {63'd0, load_done}, 64'd1);
    chk("mr_word_cnt2",   {57'd0, word_cnt},  64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
